// File: rtl/paddsb_seq_if.sv
// paddsb_seq_if: operand/result handshake bundle for the PADDSB sequencer.
// sat_lanes exists only when PADDSB_SAT_FLAGS_EN is defined.
interface paddsb_seq_if #(
   parameter int LANE_W = 4,
   parameter int NUM_LANES = 4
);
   localparam int W = LANE_W * NUM_LANES;
   logic in_valid;
   logic in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic abort;
   logic out_valid;
   logic out_ready;
   logic [W-1:0] Sum;
   logic busy;
`ifdef PADDSB_SAT_FLAGS_EN
   logic [NUM_LANES-1:0] sat_lanes;
`endif
   modport master (
      output in_valid, A, B, abort, out_ready,
      input in_ready, out_valid, Sum, busy
`ifdef PADDSB_SAT_FLAGS_EN
      , input sat_lanes
`endif
   );
   modport slave (
      input in_valid, A, B, abort, out_ready,
      output in_ready, out_valid, Sum, busy
`ifdef PADDSB_SAT_FLAGS_EN
      , output sat_lanes
`endif
   );
endinterface

// File: rtl/paddsb_seq.sv
// paddsb_seq: packed saturating lane add, one shared adder, one lane per clock.
// Optional PADDSB_SAT_FLAGS_EN adds per-lane saturation flags (bus.sat_lanes).
module paddsb_seq #(
   parameter int LANE_W = 4,
   parameter int NUM_LANES = 4
) (
   input logic clk,
   input logic rst_n,
   paddsb_seq_if.slave bus
);
   localparam int W = LANE_W * NUM_LANES;
   localparam int CW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_LANES - 1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic [W-1:0] r_a, r_b, r_sum;
   logic [LANE_W-1:0] w_la, w_lb, w_raw, w_res;
   logic w_ovf, w_accept, w_step;
   assign w_la = r_a[r_cnt*LANE_W +: LANE_W];
   assign w_lb = r_b[r_cnt*LANE_W +: LANE_W];
   assign w_raw = w_la + w_lb;
   assign w_ovf = (w_la[LANE_W-1] == w_lb[LANE_W-1]) && (w_raw[LANE_W-1] != w_la[LANE_W-1]);
   // on overflow the operand sign picks the clamp: 1 -> 100..0, 0 -> 011..1
   assign w_res = w_ovf ? {w_la[LANE_W-1], {(LANE_W-1){~w_la[LANE_W-1]}}} : w_raw;
   assign w_accept = (r_state == IDLE) && bus.in_valid;
   assign w_step = (r_state == CALC) && !bus.abort;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: w_next = bus.in_valid ? CALC : IDLE;
         CALC: w_next = bus.abort ? IDLE : (r_cnt == LAST ? DONE : CALC);
         DONE: w_next = (bus.abort || bus.out_ready) ? IDLE : DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_a <= '0;
         r_b <= '0;
         r_sum <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_a <= bus.A;
            r_b <= bus.B;
            r_sum <= '0;
            r_cnt <= '0;
         end else if (w_step) begin
            r_sum[r_cnt*LANE_W +: LANE_W] <= w_res;
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
         end else if (bus.abort) begin
            r_cnt <= '0;
         end
      end
   end
`ifdef PADDSB_SAT_FLAGS_EN
   logic [NUM_LANES-1:0] r_sat;
   always_ff @(posedge clk) begin
      if (!rst_n) r_sat <= '0;
      else if (w_accept) r_sat <= '0;
      else if (w_step) r_sat[r_cnt] <= w_ovf;
   end
   assign bus.sat_lanes = r_sat;
`endif
   assign bus.in_ready = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.busy = (r_state != IDLE);
   assign bus.Sum = r_sum;
endmodule

// File: tb/tb_paddsb_seq.sv
// tb_paddsb_seq: scoreboard bench for paddsb_seq with a clamp-based lane model.
// Checks sat_lanes too when PADDSB_SAT_FLAGS_EN is defined.
module tb_paddsb_seq;
   localparam int LW = 4;
   localparam int NL = 4;
   localparam int MAXV = (1 << (LW - 1)) - 1;
   localparam int MINV = -(1 << (LW - 1));
   typedef struct {
      logic [15:0] sum;
      logic [3:0] sat;
      int acc;
      bit seen;
   } exp_t;
   logic clk = 0;
   logic rst_n = 0;
   int cyc = 0;
   int nvec = 0;
   int nerr = 0;
   exp_t q[$];
   paddsb_seq_if #(.LANE_W(LW), .NUM_LANES(NL)) bus ();
   paddsb_seq #(.LANE_W(LW), .NUM_LANES(NL)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   task automatic chk(input string n, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic int lane(input logic [15:0] v, input int i);
      int x;
      x = int'(v[i*LW +: LW]);
      return x > MAXV ? x - (1 << LW) : x;
   endfunction
   function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, output logic [3:0] sat);
      logic [15:0] r;
      int s;
      r = '0;
      sat = '0;
      for (int i = 0; i < NL; i++) begin
         s = lane(a, i) + lane(b, i);
         if (s > MAXV || s < MINV) sat[i] = 1'b1;
         s = s > MAXV ? MAXV : (s < MINV ? MINV : s);
         r[i*LW +: LW] = LW'(s);
      end
      return r;
   endfunction
   // monitor: compare every DONE cycle against the head, pop on handshake
   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL stale_result: out_valid with Sum=%h, nothing expected", bus.Sum);
         end else begin
            if (!q[0].seen) begin
               chk("latency", cyc - q[0].acc, 5);
               q[0].seen = 1;
            end
            chk("sum", int'(bus.Sum), int'(q[0].sum));
`ifdef PADDSB_SAT_FLAGS_EN
            chk("sat_lanes", int'(bus.sat_lanes), int'(q[0].sat));
`endif
            if (bus.out_ready) void'(q.pop_front());
         end
      end
   end
   // abort_at < 0: run to completion; else interrupt after abort_at extra CALC cycles
   task automatic op(input logic [15:0] a, input logic [15:0] b, input int stall,
                     input int abort_at, input bit use_rst, input bit abort_acc);
      exp_t e;
      int n;
      n = 0;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("in_ready_wait", int'(bus.in_ready), 1);
      bus.in_valid = 1;
      bus.A = a;
      bus.B = b;
      bus.abort = abort_acc;
      bus.out_ready = (stall == 0);
      if (abort_at < 0) begin
         e.sum = model(a, b, e.sat);
         e.acc = cyc;
         e.seen = 0;
         q.push_back(e);
      end
      tick();
      bus.in_valid = 0;
      bus.abort = 0;
      bus.A = 16'($urandom);
      bus.B = 16'($urandom);
      chk("busy_calc", int'(bus.busy), 1);
      chk("in_ready_calc", int'(bus.in_ready), 0);
      if (abort_at >= 0) begin
         repeat (abort_at) tick();
         if (use_rst) rst_n = 0;
         else bus.abort = 1;
         tick();
         rst_n = 1;
         bus.abort = 0;
         chk("busy_after_cancel", int'(bus.busy), 0);
         chk("out_valid_after_cancel", int'(bus.out_valid), 0);
         chk("in_ready_after_cancel", int'(bus.in_ready), 1);
         if (use_rst) chk("sum_after_reset", int'(bus.Sum), 0);
         bus.out_ready = 0;
         return;
      end
      n = 0;
      while (!bus.out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("out_valid_wait", int'(bus.out_valid), 1);
      repeat (stall) begin
         bus.in_valid = 1;
         bus.A = 16'hFFFF;
         tick();
         chk("in_ready_done", int'(bus.in_ready), 0);
         chk("out_valid_held", int'(bus.out_valid), 1);
      end
      bus.in_valid = 0;
      bus.out_ready = 1;
      tick();
      bus.out_ready = 0;
      chk("out_valid_clear", int'(bus.out_valid), 0);
      chk("in_ready_idle", int'(bus.in_ready), 1);
   endtask
   initial begin
      bus.in_valid = 0;
      bus.A = '0;
      bus.B = '0;
      bus.abort = 0;
      bus.out_ready = 0;
      repeat (3) tick();
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_sum", int'(bus.Sum), 0);
`ifdef PADDSB_SAT_FLAGS_EN
      chk("rst_sat", int'(bus.sat_lanes), 0);
`endif
      rst_n = 1;
      tick();
      op(16'h1234, 16'h1111, 0, -1, 0, 0);
      op(16'h7F80, 16'h1F8F, 0, -1, 0, 0);
      op(16'h7777, 16'h1111, 1, -1, 0, 0);
      op(16'h8888, 16'h8888, 0, -1, 0, 0);
      op(16'h5A3C, 16'h2B71, 3, -1, 0, 0);
      op(16'h4321, 16'h1234, 0, 1, 0, 0);
      op(16'h0001, 16'h0001, 0, -1, 0, 0);
      op(16'h7000, 16'h7000, 0, 2, 1, 0);
      op(16'h0F0F, 16'h0101, 0, -1, 0, 1);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(7) == 0)
            op(16'($urandom), 16'($urandom), 0, int'($urandom_range(3)), $urandom_range(1) == 1, 0);
         else
            op(16'($urandom), 16'($urandom), int'($urandom_range(3)), -1, 0, $urandom_range(3) == 0);
      end
      repeat (8) tick();
      chk("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
